// File: rtl/alu_iter.sv
// alu_iter: handshaked ALU for the RISC-V datapath.
// Single-cycle ops: add, sub, and, or, xor, slt, sltu, sll, srl, sra.
// Iterative ops: mul/mulhu (shift-add) and divu/remu (restoring). Each takes
// WIDTH cycles.
//
// Ports
//   clk, reset_n           clock, asynchronous active-low reset
//   in_valid / in_ready    operation handshake; a, b, alucontrol are sampled on transfer
//   out_valid / out_ready  result handshake
//   result, Z, N, C, V     registered result and flags
//   illegal                registered; set when the accepted opcode is unused
//
// state | meaning
// IDLE  | accepting ops; single-cycle results load directly
// MUL   | one shift-add step per cycle, multiplier LSB first
// DIV   | one restoring-division step per cycle, quotient MSB first
module alu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alucontrol,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             Z,
    output logic             N,
    output logic             C,
    output logic             V,
    output logic             illegal
);

    localparam int SW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_SLT   = 4'b0101;
    localparam logic [3:0] OP_SLTU  = 4'b0110;
    localparam logic [3:0] OP_SLL   = 4'b0111;
    localparam logic [3:0] OP_SRL   = 4'b1000;
    localparam logic [3:0] OP_SRA   = 4'b1001;
    localparam logic [3:0] OP_MUL   = 4'b1010;
    localparam logic [3:0] OP_MULHU = 4'b1011;
    localparam logic [3:0] OP_DIVU  = 4'b1100;
    localparam logic [3:0] OP_REMU  = 4'b1101;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t             state_q, state_d;
    logic               ready_q;
    logic [SW-1:0]      count_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   opnd_q;
    logic               hi_q;

    logic in_fire, out_fire, is_mul, is_div, last;

    // ready_q keeps in_ready low during reset and for the release cycle.
    assign in_ready = ready_q && (state_q == IDLE) && (!out_valid || out_ready);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign is_mul   = (alucontrol == OP_MUL)  || (alucontrol == OP_MULHU);
    assign is_div   = (alucontrol == OP_DIVU) || (alucontrol == OP_REMU);
    assign last     = (count_q == SW'(WIDTH - 1));

    // Single-cycle datapath. slt reuses the subtract path.
    logic             sub_en, ovf;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum_ext;
    logic [SW-1:0]    shamt;
    logic [WIDTH-1:0] sc_res;
    logic             sc_c, sc_v, sc_ill;

    assign sub_en  = (alucontrol != OP_ADD);
    assign b_eff   = sub_en ? ~b : b;
    assign sum_ext = {1'b0, a} + {1'b0, b_eff} + (WIDTH+1)'(sub_en);
    assign ovf     = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
    assign shamt   = b[SW-1:0];

    always_comb begin
        sc_res = '0;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        sc_ill = 1'b0;
        case (alucontrol)
            OP_ADD, OP_SUB: begin
                sc_res = sum_ext[WIDTH-1:0];
                sc_c   = sum_ext[WIDTH];
                sc_v   = ovf;
            end
            OP_AND:  sc_res = a & b;
            OP_OR:   sc_res = a | b;
            OP_XOR:  sc_res = a ^ b;
            OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, sum_ext[WIDTH-1] ^ ovf};
            OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL:  sc_res = a << shamt;
            OP_SRL:  sc_res = a >> shamt;
            OP_SRA:  sc_res = $unsigned($signed(a) >>> shamt);
            OP_MUL, OP_MULHU, OP_DIVU, OP_REMU: sc_res = '0;
            default: sc_ill = 1'b1;
        endcase
    end

    // Iterative step. acc_q is {product_hi, multiplier} for MUL and
    // {remainder, dividend/quotient} for DIV.
    logic [WIDTH:0]     mul_sum, div_sh;
    logic [2*WIDTH-1:0] mul_next, div_next, step_next;
    logic [WIDTH-1:0]   div_diff, div_rem, iter_res;
    logic               div_ge;

    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // The partial remainder is always below the divisor, so the difference
    // fits in WIDTH bits. A zero divisor yields all-ones quotient and rem = a.
    assign div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ge   = (div_sh >= {1'b0, opnd_q});
    assign div_diff = div_sh[WIDTH-1:0] - opnd_q;
    assign div_rem  = div_ge ? div_diff : div_sh[WIDTH-1:0];
    assign div_next = {div_rem, acc_q[WIDTH-2:0], div_ge};

    assign step_next = (state_q == MUL) ? mul_next : div_next;
    assign iter_res  = hi_q ? step_next[2*WIDTH-1:WIDTH] : step_next[WIDTH-1:0];

    // Next-state and output-load decision.
    logic             load;
    logic [WIDTH-1:0] load_res;
    logic             load_c, load_v, load_ill;

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        load_res = '0;
        load_c   = 1'b0;
        load_v   = 1'b0;
        load_ill = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_fire) begin
                    if (is_mul) begin
                        state_d = MUL;
                    end else if (is_div) begin
                        state_d = DIV;
                    end else begin
                        load     = 1'b1;
                        load_res = sc_res;
                        load_c   = sc_c;
                        load_v   = sc_v;
                        load_ill = sc_ill;
                    end
                end
            end
            MUL, DIV: begin
                if (last) begin
                    state_d  = IDLE;
                    load     = 1'b1;
                    load_res = iter_res;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_q <= 1'b0;
            count_q <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            hi_q    <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            if (in_fire && (is_mul || is_div)) begin
                acc_q   <= {{WIDTH{1'b0}}, a};
                opnd_q  <= b;
                hi_q    <= (alucontrol == OP_MULHU) || (alucontrol == OP_REMU);
                count_q <= '0;
            end else if (state_q != IDLE) begin
                acc_q   <= step_next;
                count_q <= count_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            Z         <= 1'b0;
            N         <= 1'b0;
            C         <= 1'b0;
            V         <= 1'b0;
            illegal   <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            result    <= load_res;
            Z         <= (load_res == '0);
            N         <= load_res[WIDTH-1];
            C         <= load_c;
            V         <= load_v;
            illegal   <= load_ill;
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

endmodule
